// File: rtl/decoder_arbiter_16_if.sv
// Request/grant bundle for the 16-way round-robin arbiter.
interface decoder_arbiter_16_if;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    modport master (
        output req, done,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, grant_valid, timeout
    );
endinterface

// File: rtl/decoder_arbiter_16.sv
// 16-way round-robin arbiter with one-hot grant and bounded hold time.
module decoder_arbiter_16 #(
    parameter int unsigned HOLD_MAX = 15
) (
    input logic                  clk,
    input logic                  rst,
    decoder_arbiter_16_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] grant_q, grant_d;
    logic        timeout_q, timeout_d;

    logic [3:0]  win;
    logic [3:0]  cand;
    logic        found;
    logic        rel;

    // First requester at or above ptr, wrapping 15 -> 0.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        cand  = ptr_q;
        for (int i = 0; i < 16; i++) begin
            cand = ptr_q + 4'(i);
            if (!found && bus.req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        rel       = bus.done || !bus.req[idx_q];
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    idx_d   = win;
                    ptr_d   = win + 4'd1;
                    cnt_d   = 8'd0;
                end
            end
            GRANT: begin
                // A release wins over an expiring hold; no timeout then.
                if (rel) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'(HOLD_MAX - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = (state_d == GRANT) ? (16'd1 << idx_d) : 16'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            ptr_q     <= 4'd0;
            cnt_q     <= 8'd0;
            grant_q   <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = (state_q == GRANT);
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_decoder_arbiter_16.sv
// Self-checking bench for decoder_arbiter_16: vector table plus corner sequences.
module tb_decoder_arbiter_16;
    logic clk = 1'b0;
    logic rst = 1'b1;

    decoder_arbiter_16_if bus ();

    decoder_arbiter_16 #(.HOLD_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        done;
        logic [3:0]  idx;
        logic        v;
        logic        to;
    } vec_t;

    typedef struct {
        logic       chk_idx;
        logic [3:0] idx;
        logic       v;
        logic       to;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, req_v);
        end
    endtask

    task automatic step(input logic r, input logic [15:0] q, input logic d,
                        input logic [3:0] ei, input logic ev, input logic et);
        exp_t e;
        logic [15:0] eg;
        rst      = r;
        bus.req  = q;
        bus.done = d;
        sb.push_back('{chk_idx: (ev || r), idx: ei, v: ev, to: et});
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        eg = e.v ? (16'd1 << e.idx) : 16'd0;
        chk("grant", bus.grant, eg);
        chk("grant_valid", {15'd0, bus.grant_valid}, {15'd0, e.v});
        chk("timeout", {15'd0, bus.timeout}, {15'd0, e.to});
        if (e.chk_idx)
            chk("grant_idx", {12'd0, bus.grant_idx}, {12'd0, e.idx});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req  = 16'd0;
        bus.done = 1'b0;

        tbl.push_back('{1, 16'h0000, 0,  0, 0, 0});
        tbl.push_back('{0, 16'h0014, 0,  2, 1, 0});
        tbl.push_back('{0, 16'h0014, 1,  2, 0, 0});
        tbl.push_back('{0, 16'h0014, 0,  4, 1, 0});
        tbl.push_back('{0, 16'h3F14, 0,  4, 1, 0});
        tbl.push_back('{0, 16'h0014, 1,  4, 0, 0});
        tbl.push_back('{0, 16'h0014, 0,  2, 1, 0});
        tbl.push_back('{0, 16'h0014, 1,  2, 0, 0});
        tbl.push_back('{0, 16'h0014, 1,  4, 1, 0});
        tbl.push_back('{0, 16'h0014, 1,  4, 0, 0});
        tbl.push_back('{0, 16'h4000, 0, 14, 1, 0});
        tbl.push_back('{0, 16'h8001, 0, 14, 0, 0});
        tbl.push_back('{0, 16'h8001, 0, 15, 1, 0});
        tbl.push_back('{0, 16'h8001, 1, 15, 0, 0});
        tbl.push_back('{0, 16'h8001, 0,  0, 1, 0});
        tbl.push_back('{0, 16'h8001, 1,  0, 0, 0});

        // Reset, then ten idle cycles with no requests.
        step(1, 16'h0000, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 16'h0000, 0, 0, 0, 0);

        foreach (tbl[k])
            step(tbl[k].rst, tbl[k].req, tbl[k].done,
                 tbl[k].idx, tbl[k].v, tbl[k].to);

        // Hold expiry: 15 granted cycles, timeout with the drop, re-grant.
        step(0, 16'h0008, 0, 3, 1, 0);
        for (int i = 0; i < 14; i++)
            step(0, 16'h0008, 0, 3, 1, 0);
        step(0, 16'h0008, 0, 3, 0, 1);
        step(0, 16'h0008, 0, 3, 1, 0);

        // Release on the final hold cycle suppresses timeout.
        for (int i = 0; i < 14; i++)
            step(0, 16'h0008, 0, 3, 1, 0);
        step(0, 16'h0008, 1, 3, 0, 0);
        step(0, 16'h0000, 0, 0, 0, 0);

        // Reset mid-grant drops grant and rewinds the pointer.
        step(0, 16'h0200, 0, 9, 1, 0);
        step(1, 16'h0202, 0, 0, 0, 0);
        step(0, 16'h0202, 0, 1, 1, 0);

        // A reset pulse between edges must be ignored.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        step(0, 16'h0202, 0, 1, 1, 0);
        step(0, 16'h0202, 1, 1, 0, 0);
        step(0, 16'h0000, 0, 0, 0, 0);

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decoder_arbiter_16.md
DECODER_ARBITER_16 -- requirements
Module: decoder_arbiter_16

Interface
REQ-001 Parameter: HOLD_MAX, default 15, maximum cycles a grant may be held before forced revoke (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  synchronous reset, active-high, sampled on rising clk.
REQ-004 req  input  16  request lines, bit n = requester n.
REQ-005 done  input  1  current grantee releases the resource.
REQ-006 grant  output  16  one-hot grant, registered; all-zero when no grant.
REQ-007 grant_idx  output  4  binary index of current grantee, registered.
REQ-008 grant_valid  output  1  high while a grant is held.
REQ-009 timeout  output  1  single-cycle pulse on forced revoke.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 IDLE: if req != 0, the block SHALL select the first set bit at or after pointer ptr, searching upward with wrap 15->0, and enter GRANT on the next edge.
REQ-012 IDLE with req == 0: the block SHALL remain in IDLE with grant = 0 and grant_valid = 0.
REQ-013 Latency: grant SHALL become visible exactly 1 cycle after the edge at which req is sampled in IDLE.
REQ-014 On entering GRANT, the block SHALL load grant_idx = winner, set grant_valid = 1, load ptr = winner+1 mod 16, and clear the hold counter.
REQ-015 grant SHALL always equal the 4-to-16 decode of grant_idx gated by grant_valid: exactly one bit set in GRANT, zero in IDLE.
REQ-016 GRANT: the hold counter (8-bit) SHALL increment every cycle the grant is held.
REQ-017 GRANT SHALL exit to IDLE on the next edge when done = 1 or req[grant_idx] = 0 (release).
REQ-018 GRANT SHALL exit to IDLE on the next edge when the counter equals HOLD_MAX-1 without release, and timeout SHALL pulse for that one cycle (coincident with grant_valid falling).
REQ-019 Release and timeout in the same cycle: the revoke SHALL be treated as a release; timeout SHALL stay 0.
REQ-020 After any exit, the block SHALL spend exactly one IDLE cycle (grant = 0) before the next grant; back-to-back grants are therefore separated by one bubble.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 Changes to req bits other than grant_idx during GRANT SHALL NOT affect the held grant.
REQ-023 ptr wrap: a win by requester 15 SHALL set ptr = 0.

Reset
REQ-024 With rst = 1 at a rising edge, the block SHALL enter IDLE and set grant = 16'h0000, grant_idx = 0, grant_valid = 0, timeout = 0, ptr = 0, hold counter = 0.
REQ-025 Reset SHALL take priority over every other event, including mid-GRANT; grant SHALL drop on that same edge.
REQ-026 Reset SHALL be synchronous only; rst changes between edges SHALL have no effect.

Verification
REQ-027 Reset then req = 16'h0000 for 10 cycles -> grant = 0, grant_valid = 0, timeout = 0 throughout.
REQ-028 From reset, req = 16'h0014 held, done pulsed 1 cycle after each grant -> grant_idx sequence 2, 4, 2, 4, one idle cycle between grants.
REQ-029 ptr = 15 (after a win by 14), req = 16'h8001 -> grant_idx = 15, then 0 after release (wrap).
REQ-030 HOLD_MAX = 15, req = 16'h0008 held, done = 0 -> grant = 16'h0008 for exactly 15 cycles, timeout = 1 for one cycle as grant falls, then re-grant to 3 after one idle cycle.
REQ-031 done = 1 on the cycle the counter reaches HOLD_MAX-1 -> grant released, timeout = 0.
REQ-032 rst = 1 mid-GRANT with grant_idx = 9 -> grant = 0 on that edge; next arbitration starts at ptr = 0 (req = 16'h0202 -> grant_idx = 1).
